// File: rtl/error_calculator_mc.sv
// Multi-channel noise-cancel error path with per-channel lock/unlock tracking.
// Optional ERRCALC_SATURATE_EN: negation of the most-negative sample saturates.
module error_calculator_mc #(
  parameter int DATA_WIDTH   = 16,
  parameter int THRESH_WIDTH = 8,
  parameter int NUM_CH       = 2,
  parameter int WINDOW       = 256,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           nc_on,
  input  logic                           error_ready,
  input  logic [CH_W-1:0]                ch_in,
  input  logic signed [DATA_WIDTH-1:0]   feedback_in,
  input  logic signed [THRESH_WIDTH-1:0] lock_low_in,
  input  logic signed [THRESH_WIDTH-1:0] lock_high_in,
  input  logic signed [THRESH_WIDTH-1:0] unlock_low_in,
  input  logic signed [THRESH_WIDTH-1:0] unlock_high_in,
  output logic signed [DATA_WIDTH-1:0]   error_out,
  output logic [CH_W-1:0]                ch_out,
  output logic                           done_out,
  output logic [NUM_CH-1:0]              error_locked_out
);

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam int IDX_W = CH_W + 1;
  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);
  localparam logic signed [DATA_WIDTH-1:0] MIN_V =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] MAX_V =
    {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q [NUM_CH];
  logic [CNT_W-1:0] lock_q  [NUM_CH];
  logic [CNT_W-1:0] bad_q   [NUM_CH];

  state_t           state_d;
  logic [CNT_W-1:0] lock_d;
  logic [CNT_W-1:0] bad_d;
  logic [CNT_W-1:0] lock_inc;
  logic [CNT_W-1:0] bad_inc;

  logic            accept;
  logic [CH_W-1:0] sel;
  logic            in_lock;
  logic            in_safe;

  logic signed [DATA_WIDTH-1:0] ll;
  logic signed [DATA_WIDTH-1:0] lh;
  logic signed [DATA_WIDTH-1:0] ul;
  logic signed [DATA_WIDTH-1:0] uh;
  logic signed [DATA_WIDTH-1:0] neg;

  assign accept = error_ready &&
                  ({1'b0, ch_in} < IDX_W'(NUM_CH));
  // Out-of-range channels never reach the state arrays
  assign sel = accept ? ch_in : '0;

  assign ll = DATA_WIDTH'(lock_low_in);
  assign lh = DATA_WIDTH'(lock_high_in);
  assign ul = DATA_WIDTH'(unlock_low_in);
  assign uh = DATA_WIDTH'(unlock_high_in);

  assign in_lock = (ll < feedback_in) && (feedback_in < lh);
  assign in_safe = (ul < feedback_in) && (feedback_in < uh);

`ifdef ERRCALC_SATURATE_EN
  assign neg = (feedback_in == MIN_V) ? MAX_V : -feedback_in;
`else
  assign neg = -feedback_in;
`endif

  always_comb begin
    state_d  = state_q[sel];
    lock_d   = lock_q[sel];
    bad_d    = bad_q[sel];
    lock_inc = lock_q[sel] + CNT_W'(1);
    bad_inc  = bad_q[sel] + CNT_W'(1);
    unique case (state_q[sel])
      UNLOCKED: begin
        if (!in_lock) begin
          lock_d = '0;
        end else if (lock_inc == WIN) begin
          state_d = LOCKED;
          lock_d  = '0;
          bad_d   = '0;
        end else begin
          lock_d = lock_inc;
        end
      end
      LOCKED: begin
        if (in_safe) begin
          bad_d = '0;
        end else if (bad_inc == WIN) begin
          state_d = UNLOCKED;
          lock_d  = '0;
          bad_d   = '0;
        end else begin
          bad_d = bad_inc;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= UNLOCKED;
        lock_q[c]  <= '0;
        bad_q[c]   <= '0;
      end
      error_out <= '0;
      ch_out    <= '0;
      done_out  <= 1'b0;
    end else begin
      done_out <= accept;
      if (accept) begin
        state_q[sel] <= state_d;
        lock_q[sel]  <= lock_d;
        bad_q[sel]   <= bad_d;
        // Error reflects the lock state held before this sample
        error_out <= (nc_on && state_q[sel] == UNLOCKED) ? neg : '0;
        ch_out    <= ch_in;
      end
    end
  end

  always_comb begin
    error_locked_out = '0;
    for (int c = 0; c < NUM_CH; c++)
      error_locked_out[c] = (state_q[c] == LOCKED);
  end

endmodule

// File: tb/tb_error_calculator_mc.sv
// Scoreboard bench for error_calculator_mc (NUM_CH=3, WINDOW=256).
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_error_calculator_mc;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic               nc_on = 1'b0;
  logic               error_ready = 1'b0;
  logic [1:0]         ch_in = '0;
  logic signed [15:0] feedback_in = '0;
  logic signed [7:0]  lock_low_in = -8'sd10;
  logic signed [7:0]  lock_high_in = 8'sd10;
  logic signed [7:0]  unlock_low_in = -8'sd50;
  logic signed [7:0]  unlock_high_in = 8'sd50;
  logic signed [15:0] error_out;
  logic [1:0]         ch_out;
  logic               done_out;
  logic [2:0]         error_locked_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]         ch;
    logic signed [15:0] err;
    logic [2:0]         lk;
  } exp_t;

  exp_t sb[$];

  error_calculator_mc #(
    .DATA_WIDTH(16), .THRESH_WIDTH(8), .NUM_CH(3), .WINDOW(256)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .nc_on(nc_on),
    .error_ready(error_ready), .ch_in(ch_in),
    .feedback_in(feedback_in),
    .lock_low_in(lock_low_in), .lock_high_in(lock_high_in),
    .unlock_low_in(unlock_low_in), .unlock_high_in(unlock_high_in),
    .error_out(error_out), .ch_out(ch_out), .done_out(done_out),
    .error_locked_out(error_locked_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (!rst_in && done_out) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got ch=%0d err=%0d", ch_out, error_out);
      end else begin
        e = sb.pop_front();
        if (ch_out !== e.ch || error_out !== e.err ||
            error_locked_out !== e.lk) begin
          errors++;
          $display("FAIL sample got ch=%0d err=%0d lk=%b want ch=%0d err=%0d lk=%b",
                   ch_out, error_out, error_locked_out, e.ch, e.err, e.lk);
        end
      end
    end
  end

  task automatic send(input logic [1:0] ch, input logic signed [15:0] fb,
                      input logic nc, input logic push_it,
                      input logic signed [15:0] err, input logic [2:0] lk);
    @(posedge clk_in);
    #1;
    error_ready = 1'b1;
    ch_in = ch;
    feedback_in = fb;
    nc_on = nc;
    if (push_it) sb.push_back('{ch: ch, err: err, lk: lk});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_in);
      #1;
      error_ready = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic pulse_reset(input logic check);
    idle(3);
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    if (check) begin
      chk("rst_err", int'(error_out), 0);
      chk("rst_ch", int'(ch_out), 0);
      chk("rst_done", int'(done_out), 0);
      chk("rst_lock", int'(error_locked_out), 0);
    end
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout pending=%0d", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [15:0] sat_exp;
`ifdef ERRCALC_SATURATE_EN
    sat_exp = 16'sd32767;
`else
    sat_exp = -16'sd32768;
`endif
    #23;
    chk("init_err", int'(error_out), 0);
    chk("init_done", int'(done_out), 0);
    chk("init_lock", int'(error_locked_out), 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    send(2'd2, -16'sd32768, 1'b1, 1'b1, sat_exp, 3'b000);
    send(2'd3, 16'sd5, 1'b1, 1'b0, '0, '0);

    for (int i = 0; i < 256; i++)
      send(2'd0, 16'sd5, 1'b1, 1'b1, -16'sd5,
           (i == 255) ? 3'b001 : 3'b000);
    send(2'd0, 16'sd5, 1'b1, 1'b1, 16'sd0, 3'b001);

    for (int i = 0; i < 255; i++)
      send(2'd0, 16'sd60, 1'b1, 1'b1, 16'sd0, 3'b001);
    send(2'd0, 16'sd0, 1'b1, 1'b1, 16'sd0, 3'b001);
    for (int i = 0; i < 256; i++)
      send(2'd0, 16'sd60, 1'b1, 1'b1, 16'sd0,
           (i == 255) ? 3'b000 : 3'b001);
    send(2'd0, 16'sd60, 1'b1, 1'b1, -16'sd60, 3'b000);

    for (int i = 0; i < 512; i++) begin
      if (i % 2 == 0)
        send(2'd0, 16'sd3, 1'b1, 1'b1, -16'sd3,
             (i >= 510) ? 3'b001 : 3'b000);
      else
        send(2'd1, 16'sd100, 1'b1, 1'b1, -16'sd100,
             (i == 511) ? 3'b001 : 3'b000);
    end

    pulse_reset(1'b1);

    for (int i = 0; i < 100; i++) begin
      send(2'd0, 16'sd5, 1'b0, 1'b1, 16'sd0, 3'b000);
      if (i % 10 == 0) send(2'd3, 16'sd50, 1'b1, 1'b0, '0, '0);
    end

    pulse_reset(1'b0);

    for (int i = 0; i < 256; i++)
      send(2'd0, 16'sd5, 1'b1, 1'b1, -16'sd5,
           (i == 255) ? 3'b001 : 3'b000);
    idle(4);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
